// File: rtl/reg_read_packetiser_pkg.sv
// ============================================================================
// reg_read_packetiser_pkg
// Shared types and constants for the register-read return path.
//   UART_PACKET       : byte-wide stream record toward the UART transmitter
//   rd_state_t        : packetiser FSM states (also used by bench monitors)
//   RD_DATA_LENGTH    : data bytes per register word
//   RD_CSUM_BYTES     : 1 when the trailing XOR checksum byte is built in
//   RD_PACKET_LENGTH  : value carried in the Length field of every byte
// Optional feature macro: RD_CHECKSUM_EN (adds the checksum byte).
// ============================================================================
package reg_read_packetiser_pkg;

    typedef struct packed {
        logic [7:0] Source;
        logic [7:0] Destination;
        logic [7:0] Length;
        logic       SoP;
        logic       EoP;
        logic [7:0] Data;
        logic       Valid;
    } UART_PACKET;

    typedef enum logic [2:0] {
        RD_IDLE      = 3'd0,
        RD_READ      = 3'd1,
        RD_WAIT_DATA = 3'd2,
        RD_SEND_ADDR = 3'd3,
        RD_SEND_DATA = 3'd4,
        RD_SEND_CSUM = 3'd5
    } rd_state_t;

    localparam int RD_DATA_LENGTH = 4;

`ifdef RD_CHECKSUM_EN
    localparam int RD_CSUM_BYTES = 1;
`else
    localparam int RD_CSUM_BYTES = 0;
`endif

    localparam int RD_PACKET_LENGTH = 1 + RD_DATA_LENGTH + RD_CSUM_BYTES;

endpackage

// File: rtl/reg_read_packetiser_if.sv
// ============================================================================
// reg_read_packetiser_if
// UART_PACKET stream toward the UART transmitter.
//   Stream : packet record (Source, Destination, Length, SoP, EoP, Data, Valid)
//   Ready  : sink can accept the current byte
// A byte transfers on a rising edge where Stream.Valid && Ready. While Valid is
// high and Ready is low, the source holds Valid, Data, SoP and EoP unchanged.
// master: packet source (drives Stream); slave: packet sink (drives Ready).
// ============================================================================
interface reg_read_packetiser_if;
    import reg_read_packetiser_pkg::*;

    UART_PACKET Stream;
    logic       Ready;

    modport master (output Stream, input Ready);
    modport slave  (input Stream, output Ready);
endinterface

// File: rtl/reg_read_packetiser.sv
// ============================================================================
// reg_read_packetiser
// Register bridge return path. A read request fetches one register word and
// serialises it as: address byte (SoP), data bytes MSB first, and optionally
// an XOR checksum byte; the last byte carries EoP.
// Ports:
//   ipClk        clock
//   ipReset      synchronous active-high reset, registered once before use
//   ipRdRequest  one-cycle request, accepted only while idle
//   ipRdAddress  register address captured with the request
//   opRdAddress  address to the register file
//   opRdEnable   one-cycle read strobe to the register file
//   ipRdData     register read data, qualified by ipRdValid
//   ipRdValid    read data valid (any latency >= 1 after opRdEnable)
//   opRxStream   UART_PACKET stream (master side, Ready inside the interface)
//   opBusy       high from accepted request until last byte handshaken
//   opDbgState   current FSM state, for monitors
// Optional feature macro: RD_CHECKSUM_EN (trailing XOR checksum byte).
// ============================================================================
module reg_read_packetiser
    import reg_read_packetiser_pkg::*;
#(
    parameter logic [7:0] SOURCE_ID   = 8'h01,
    parameter logic [7:0] DEST_ID     = 8'h00,
    parameter int         DATA_LENGTH = RD_DATA_LENGTH
) (
    input  logic                         ipClk,
    input  logic                         ipReset,
    input  logic                         ipRdRequest,
    input  logic [7:0]                   ipRdAddress,
    output logic [7:0]                   opRdAddress,
    output logic                         opRdEnable,
    input  logic [8*DATA_LENGTH-1:0]     ipRdData,
    input  logic                         ipRdValid,
    reg_read_packetiser_if.master        opRxStream,
    output logic                         opBusy,
    output rd_state_t                    opDbgState
);

    localparam int              WORD_W   = 8 * DATA_LENGTH;
    localparam int              CNT_W    = (DATA_LENGTH > 1) ? $clog2(DATA_LENGTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_LENGTH - 1);
    localparam logic [7:0]      LENGTH   = 8'(1 + DATA_LENGTH + RD_CSUM_BYTES);

    logic              r_reset;
    rd_state_t         r_state;
    rd_state_t         w_next_state;
    logic [7:0]        r_addr;
    logic [WORD_W-1:0] r_word;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_valid;
    logic              w_sop;
    logic              w_eop;
    logic [7:0]        w_byte;
    logic [7:0]        w_data_byte;
    logic              w_hs;

    // Reset is registered once; everything else resets from the registered copy.
    always_ff @(posedge ipClk) begin
        r_reset <= ipReset;
    end

    always_ff @(posedge ipClk) begin
        if (r_reset) begin
            r_state <= RD_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    assign w_hs = w_valid && opRxStream.Ready;

    always_ff @(posedge ipClk) begin
        if (r_reset) begin
            r_addr <= '0;
            r_word <= '0;
            r_cnt  <= '0;
        end else begin
            if (r_state == RD_IDLE && ipRdRequest) begin
                r_addr <= ipRdAddress;
            end
            if (r_state == RD_WAIT_DATA && ipRdValid) begin
                r_word <= ipRdData;
            end
            // Counter is preset while the address byte is on the bus so the
            // first data byte is the most significant one.
            if (r_state == RD_SEND_ADDR) begin
                r_cnt <= CNT_LAST;
            end else if (r_state == RD_SEND_DATA && w_hs && r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    // Byte selected by the counter, decoded with constant slices.
    always_comb begin
        w_data_byte = '0;
        for (int i = 0; i < DATA_LENGTH; i++) begin
            if (r_cnt == CNT_W'(i)) begin
                w_data_byte = r_word[8*i +: 8];
            end
        end
    end

`ifdef RD_CHECKSUM_EN
    logic [7:0] w_csum;

    always_comb begin
        w_csum = r_addr;
        for (int i = 0; i < DATA_LENGTH; i++) begin
            w_csum = w_csum ^ r_word[8*i +: 8];
        end
    end
`endif

    always_comb begin
        w_next_state = r_state;
        w_valid      = 1'b0;
        w_sop        = 1'b0;
        w_eop        = 1'b0;
        w_byte       = 8'h00;
        opRdEnable   = 1'b0;
        case (r_state)
            RD_IDLE: begin
                if (ipRdRequest) begin
                    w_next_state = RD_READ;
                end
            end
            RD_READ: begin
                opRdEnable   = 1'b1;
                w_next_state = RD_WAIT_DATA;
            end
            RD_WAIT_DATA: begin
                if (ipRdValid) begin
                    w_next_state = RD_SEND_ADDR;
                end
            end
            RD_SEND_ADDR: begin
                w_valid = 1'b1;
                w_sop   = 1'b1;
                w_byte  = r_addr;
                if (opRxStream.Ready) begin
                    w_next_state = RD_SEND_DATA;
                end
            end
            RD_SEND_DATA: begin
                w_valid = 1'b1;
                w_byte  = w_data_byte;
                if (r_cnt == '0) begin
`ifdef RD_CHECKSUM_EN
                    if (opRxStream.Ready) begin
                        w_next_state = RD_SEND_CSUM;
                    end
`else
                    w_eop = 1'b1;
                    if (opRxStream.Ready) begin
                        w_next_state = RD_IDLE;
                    end
`endif
                end
            end
            RD_SEND_CSUM: begin
`ifdef RD_CHECKSUM_EN
                w_valid = 1'b1;
                w_eop   = 1'b1;
                w_byte  = w_csum;
                if (opRxStream.Ready) begin
                    w_next_state = RD_IDLE;
                end
`else
                w_next_state = RD_IDLE;
`endif
            end
            default: begin
                w_next_state = RD_IDLE;
            end
        endcase
    end

    always_comb begin
        opRxStream.Stream = '{Source:      SOURCE_ID,
                              Destination: DEST_ID,
                              Length:      LENGTH,
                              SoP:         w_sop,
                              EoP:         w_eop,
                              Data:        w_byte,
                              Valid:       w_valid};
    end

    assign opRdAddress = r_addr;
    assign opBusy      = (r_state != RD_IDLE);
    assign opDbgState  = r_state;

endmodule

// File: tb/tb_reg_read_packetiser.sv
// ============================================================================
// tb_reg_read_packetiser
// Directed bench for reg_read_packetiser. Expected stream bytes are pushed
// into exp_q when a request is issued; a monitor pops and compares on every
// stream handshake. A responder models the register file read latency.
// Build with RD_CHECKSUM_EN defined to exercise the checksum byte.
// ============================================================================
module tb_reg_read_packetiser;
    import reg_read_packetiser_pkg::*;

`ifdef RD_CHECKSUM_EN
    localparam bit         CSUM_ON = 1'b1;
    localparam logic [7:0] EXP_LEN = 8'd6;
    localparam int         EXP_SPAN = 5;
`else
    localparam bit         CSUM_ON = 1'b0;
    localparam logic [7:0] EXP_LEN = 8'd5;
    localparam int         EXP_SPAN = 4;
`endif

    // ---------------- clock / reset ----------------
    logic        ipClk = 1'b0;
    logic        ipReset = 1'b1;
    logic        ipRdRequest = 1'b0;
    logic [7:0]  ipRdAddress = 8'h00;
    logic [7:0]  opRdAddress;
    logic        opRdEnable;
    logic [31:0] ipRdData = 32'h0;
    logic        ipRdValid = 1'b0;
    logic        opBusy;
    rd_state_t   dbg_state;

    reg_read_packetiser_if rx_if ();

    always #5 ipClk = ~ipClk;

    reg_read_packetiser dut (
        .ipClk       (ipClk),
        .ipReset     (ipReset),
        .ipRdRequest (ipRdRequest),
        .ipRdAddress (ipRdAddress),
        .opRdAddress (opRdAddress),
        .opRdEnable  (opRdEnable),
        .ipRdData    (ipRdData),
        .ipRdValid   (ipRdValid),
        .opRxStream  (rx_if),
        .opBusy      (opBusy),
        .opDbgState  (dbg_state)
    );

    // ---------------- scoreboard ----------------
    logic [33:0] exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_byte(input logic [7:0] d, input logic sop, input logic eop);
        exp_q.push_back({8'h01, 8'h00, EXP_LEN, sop, eop, d});
    endtask

    task automatic push_pkt(input logic [7:0] a, input logic [31:0] w, input logic [7:0] csum);
        push_byte(a, 1'b1, 1'b0);
        push_byte(w[31:24], 1'b0, 1'b0);
        push_byte(w[23:16], 1'b0, 1'b0);
        push_byte(w[15:8], 1'b0, 1'b0);
        push_byte(w[7:0], 1'b0, !CSUM_ON);
        if (CSUM_ON) push_byte(csum, 1'b0, 1'b1);
    endtask

    // ---------------- downstream ready driver ----------------
    int rdy_mode = 0;   // 0: ready high, 1: toggle each cycle, 2: ready low
    always @(posedge ipClk) begin
        #2;
        case (rdy_mode)
            0:       rx_if.Ready = 1'b1;
            1:       rx_if.Ready = ~rx_if.Ready;
            default: rx_if.Ready = 1'b0;
        endcase
    end

    // ---------------- register file responder ----------------
    int          rd_lat = 2;
    logic [31:0] rd_word = 32'h0;
    logic [7:0]  exp_rd_addr = 8'h00;
    int          en_count = 0;

    always @(negedge ipClk) begin
        if (opRdEnable) en_count++;
    end

    always @(negedge ipClk) begin
        if (opRdEnable) begin
            check("rd_address", opRdAddress, exp_rd_addr);
            repeat (rd_lat) @(posedge ipClk);
            #1;
            ipRdData  = rd_word;
            ipRdValid = 1'b1;
            @(posedge ipClk);
            #1;
            ipRdValid = 1'b0;
        end
    end

    // ---------------- stream monitor ----------------
    bit         in_reset = 1'b1;
    bit         prev_stall = 1'b0;
    UART_PACKET prev_pkt;

    always @(negedge ipClk) begin
        UART_PACKET p;
        p = rx_if.Stream;
        if (prev_stall && !in_reset)
            check("hold_stable", {p.Valid, p.SoP, p.EoP, p.Data},
                  {1'b1, prev_pkt.SoP, prev_pkt.EoP, prev_pkt.Data});
        if (p.Valid && rx_if.Ready && !in_reset) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_byte: got data %0h sop %0b eop %0b, expected no byte (t=%0t)",
                         p.Data, p.SoP, p.EoP, $time);
            end else begin
                check("stream_byte",
                      {p.Source, p.Destination, p.Length, p.SoP, p.EoP, p.Data},
                      exp_q.pop_front());
            end
        end
        prev_stall = p.Valid && !rx_if.Ready;
        prev_pkt   = p;
    end

    // ---------------- driver tasks ----------------
    task automatic wait_idle();
        for (int i = 0; i < 300; i++) begin
            if (!opBusy) break;
            @(negedge ipClk);
        end
        check("idle_before_request", opBusy, 1'b0);
    endtask

    task automatic send_req(input logic [7:0] a, input logic [31:0] w, input int lat);
        wait_idle();
        rd_word     = w;
        rd_lat      = lat;
        exp_rd_addr = a;
        ipRdAddress = a;
        ipRdRequest = 1'b1;
        @(negedge ipClk);
        ipRdRequest = 1'b0;
    endtask

    // Waits for the EoP handshake, then checks the idle state that follows.
    task automatic wait_pkt_end(output int span);
        int  first_hs;
        bit  found;
        first_hs = -1;
        found    = 1'b0;
        span     = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge ipClk);
            if (rx_if.Stream.Valid && rx_if.Ready) begin
                if (first_hs < 0) first_hs = i;
                if (rx_if.Stream.EoP) begin
                    span  = i - first_hs;
                    found = 1'b1;
                    break;
                end
            end
        end
        if (!found) begin
            n_cmp++;
            n_bad++;
            $display("FAIL eop_timeout: got no EoP handshake, expected one within 400 cycles");
        end else begin
            @(negedge ipClk);
            check("busy_after_eop", opBusy, 1'b0);
            check("valid_after_eop", rx_if.Stream.Valid, 1'b0);
            check("queue_drained", exp_q.size(), 0);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int  span;
        int  hs;
        bit  saw_valid;

        repeat (4) @(negedge ipClk);
        check("reset_valid", rx_if.Stream.Valid, 1'b0);
        check("reset_sop_eop_data", {rx_if.Stream.SoP, rx_if.Stream.EoP, rx_if.Stream.Data}, 10'h000);
        check("reset_busy", opBusy, 1'b0);
        check("reset_rd_enable", opRdEnable, 1'b0);
        check("reset_rd_address", opRdAddress, 8'h00);
        check("reset_state", dbg_state, RD_IDLE);
        ipReset = 1'b0;
        repeat (2) @(negedge ipClk);
        in_reset = 1'b0;

        // 1: basic packet, ready held high -> back-to-back bytes
        rdy_mode = 0;
        push_pkt(8'h10, 32'hA1B2C3D4, 8'h14);
        send_req(8'h10, 32'hA1B2C3D4, 2);
        wait_pkt_end(span);
        check("t1_back_to_back_span", span, EXP_SPAN);

        // 2: ready toggling each cycle
        rdy_mode = 1;
        push_pkt(8'h10, 32'hA1B2C3D4, 8'h14);
        send_req(8'h10, 32'hA1B2C3D4, 2);
        wait_pkt_end(span);
        rdy_mode = 0;

        // 3: request during a busy packet is dropped
        en_count = 0;
        push_pkt(8'h10, 32'hA1B2C3D4, 8'h14);
        send_req(8'h10, 32'hA1B2C3D4, 2);
        repeat (2) @(negedge ipClk);
        ipRdAddress = 8'h20;
        ipRdRequest = 1'b1;
        @(negedge ipClk);
        ipRdRequest = 1'b0;
        wait_pkt_end(span);
        repeat (4) @(negedge ipClk);
        check("t3_single_read_strobe", en_count, 1);
        check("t3_still_idle", opBusy, 1'b0);

        // 4: reset after second byte handshaken, then a clean packet
        push_byte(8'h40, 1'b1, 1'b0);
        push_byte(8'h11, 1'b0, 1'b0);
        send_req(8'h40, 32'h11223344, 2);
        hs = 0;
        for (int i = 0; i < 100 && hs < 2; i++) begin
            @(negedge ipClk);
            if (rx_if.Stream.Valid && rx_if.Ready) hs++;
        end
        check("t4_two_bytes_seen", hs, 2);
        @(posedge ipClk);
        #1;
        rdy_mode = 2;
        ipReset  = 1'b1;
        in_reset = 1'b1;
        repeat (3) @(negedge ipClk);
        check("t4_valid_after_reset", rx_if.Stream.Valid, 1'b0);
        check("t4_no_eop_after_reset", rx_if.Stream.EoP, 1'b0);
        check("t4_busy_after_reset", opBusy, 1'b0);
        check("t4_aborted_bytes_consumed", exp_q.size(), 0);
        ipReset = 1'b0;
        repeat (2) @(negedge ipClk);
        in_reset = 1'b0;
        rdy_mode = 0;
        @(negedge ipClk);
        push_pkt(8'h30, 32'h00000000, 8'h30);
        send_req(8'h30, 32'h00000000, 2);
        wait_pkt_end(span);

        // 5: checksum vector (XOR of 01,01,02,03,04 = 05)
        push_pkt(8'h01, 32'h01020304, 8'h05);
        send_req(8'h01, 32'h01020304, 1);
        wait_pkt_end(span);

        // 6: long read latency, no stream activity while waiting
        en_count = 0;
        push_pkt(8'h7E, 32'hDEADBEEF, 8'h5C);
        send_req(8'h7E, 32'hDEADBEEF, 10);
        saw_valid = 1'b0;
        repeat (9) begin
            @(negedge ipClk);
            if (rx_if.Stream.Valid) saw_valid = 1'b1;
        end
        check("t6_valid_low_in_wait", saw_valid, 1'b0);
        wait_pkt_end(span);
        check("t6_single_read_strobe", en_count, 1);

        repeat (3) @(negedge ipClk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #400000;
        n_cmp++;
        n_bad++;
        $display("FAIL global_timeout: got no end of sequence, expected one before 400000");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
